// File: rtl/decoder_3x8_if.sv
// Select bus for the 3-to-8 decoder: enable and binary code in, one-hot select out.
interface decoder_3x8_if;
    logic       en;
    logic [2:0] ip;
    logic [7:0] op;

    // Driver of the code (upstream block)
    modport master (
        output en,
        output ip,
        input  op
    );

    // The decoder itself
    modport slave (
        input  en,
        input  ip,
        output op
    );
endinterface

// File: rtl/decoder_3x8.sv
// 3-to-8 one-hot decoder built from a 1-to-2 stage on ip[2] feeding two 2-to-4
// stages on ip[1:0]. The output is optionally registered so downstream blocks
// see a glitch-free select that changes only on the clock edge.
module decoder_3x8 #(
    parameter bit REGISTER_OUTPUT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decoder_3x8_if.slave  bus
);

    // Splits the enable into lower-half (bit 0) and upper-half (bit 1) enables.
    function automatic logic [1:0] dec_1to2(input logic e, input logic s);
        logic [1:0] r;
        r = 2'b00;
        if (e) begin
            r = s ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    // Quarter decoder; all zero whenever its half is not selected.
    function automatic logic [3:0] dec_2to4(input logic e, input logic [1:0] s);
        logic [3:0] r;
        r = 4'b0000;
        if (e) begin
            case (s)
                2'd0:    r = 4'b0001;
                2'd1:    r = 4'b0010;
                2'd2:    r = 4'b0100;
                default: r = 4'b1000;
            endcase
        end
        return r;
    endfunction

    logic [1:0] half_en;
    logic [7:0] dec;

    // Combinational hierarchical decode; at most one half enable is ever high,
    // so at most one output bit can be high.
    always_comb begin
        half_en = dec_1to2(bus.en, bus.ip[2]);
        dec     = {dec_2to4(half_en[1], bus.ip[1:0]),
                   dec_2to4(half_en[0], bus.ip[1:0])};
    end

    generate
        if (REGISTER_OUTPUT) begin : g_reg
            logic [7:0] op_d;
            logic [7:0] op_q;

            // Next registered value is simply the current decode.
            always_comb begin
                op_d = dec;
            end

            // Output register; reset clears it immediately, dropping any pending decode.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    op_q <= 8'h00;
                end else begin
                    op_q <= op_d;
                end
            end

            assign bus.op = op_q;
        end else begin : g_comb
            // The clock has no role in the combinational build.
            logic unused_clk;
            assign unused_clk = clk;

            // Reset still forces an all-zero select in the combinational build.
            always_comb begin
                bus.op = rst ? 8'h00 : dec;
            end
        end
    endgenerate

endmodule

// File: tb/tb_decoder_3x8.sv
// Bench for decoder_3x8: registered build (directed + random) and combinational build.
module tb_decoder_3x8;

    logic clk;
    logic rst;
    logic rst_c;
    int   total;
    int   bad;

    decoder_3x8_if rif ();
    decoder_3x8_if cif ();

    decoder_3x8 #(.REGISTER_OUTPUT(1'b1)) dut_reg (
        .clk (clk),
        .rst (rst),
        .bus (rif.slave)
    );

    decoder_3x8 #(.REGISTER_OUTPUT(1'b0)) dut_comb (
        .clk (clk),
        .rst (rst_c),
        .bus (cif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a single lit line at position ip when enabled, else nothing.
    function automatic logic [7:0] ref_dec(input logic e, input logic [2:0] i);
        logic [7:0] r;
        r = 8'h00;
        if (e) r[i] = 1'b1;
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_onehot(input string tag, input logic [7:0] obs);
        total++;
        assert ($onehot0(obs)) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=one-hot-or-zero", tag, obs);
        end
    endtask

    // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input string tag, input logic e, input logic [2:0] i);
        @(negedge clk);
        rif.en = e;
        rif.ip = i;
        @(posedge clk);
        #1;
        check(tag, rif.op, ref_dec(e, i));
        check_onehot({tag, "_1hot"}, rif.op);
    endtask

    initial begin
        logic       e;
        logic [2:0] i;
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        rst_c  = 1'b1;
        rif.en = 1'b1;
        rif.ip = 3'b101;
        cif.en = 1'b1;
        cif.ip = 3'b010;

        // Reset state of both builds
        repeat (2) @(posedge clk);
        #1;
        check("reset_reg", rif.op, 8'h00);
        check("reset_comb", cif.op, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // First edge after release decodes the sampled code
        @(posedge clk);
        #1;
        check("first_edge", rif.op, ref_dec(1'b1, 3'b101));

        // Asynchronous reset mid-cycle, no clock edge needed
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", rif.op, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", rif.op, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Full sweep
        for (int k = 0; k < 8; k++) begin
            step($sformatf("sweep%0d", k), 1'b1, 3'(k));
        end

        // Enable gating
        step("gate_on", 1'b1, 3'b011);
        step("gate_off", 1'b0, 3'b011);
        step("gate_back", 1'b1, 3'b011);

        // MSB crossing back to back
        step("msb_a", 1'b1, 3'b011);
        step("msb_b", 1'b1, 3'b100);
        step("msb_c", 1'b1, 3'b011);

        // Short reset pulse mid-stream
        step("mid_110", 1'b1, 3'b110);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst", rif.op, 8'h00);
        #1;
        rst = 1'b0;
        step("mid_111", 1'b1, 3'b111);

        // Random stream
        for (int k = 0; k < 40; k++) begin
            e = ($urandom_range(0, 3) != 0);
            i = 3'($urandom_range(0, 7));
            step($sformatf("rand%0d", k), e, i);
        end

        // Combinational build
        @(negedge clk);
        rst_c  = 1'b0;
        cif.en = 1'b1;
        cif.ip = 3'b010;
        #1;
        check("comb_010", cif.op, 8'h04);
        rst_c = 1'b1;
        #1;
        check("comb_rst", cif.op, 8'h00);
        rst_c = 1'b0;
        for (int k = 0; k < 16; k++) begin
            e = ($urandom_range(0, 3) != 0);
            i = 3'($urandom_range(0, 7));
            cif.en = e;
            cif.ip = i;
            #1;
            check($sformatf("comb_rand%0d", k), cif.op, ref_dec(e, i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
